// File: rtl/arbiter_out_fifo.sv
// arbiter_out_fifo: registered-ready valid/ready FIFO placed after the round-robin arbiter.
// Optional empty-FIFO fall-through path is enabled by defining ARB_FIFO_BYPASS_EN.
module arbiter_out_fifo #(
  parameter int DWIDTH = 16,
  parameter int DEPTH = 4,
  parameter int AFULL_LVL = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [DWIDTH-1:0]            in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [DWIDTH-1:0]            out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic init_done, empty, full, push, pop;
  assign empty = wr_ptr == rd_ptr;
  assign full = wr_ptr[AW-1:0] == rd_ptr[AW-1:0] && wr_ptr[AW] != rd_ptr[AW];
  assign in_ready = !full && init_done;
  assign almost_full = count >= CW'(AFULL_LVL);
  assign pop = !empty && out_ready;
`ifdef ARB_FIFO_BYPASS_EN
  logic byp;
  assign byp = empty && in_valid && init_done;
  assign out_valid = !empty || byp;
  assign out_data = !empty ? mem[rd_ptr[AW-1:0]] : byp ? in_data : '0;
  // a word consumed on the fall-through path never touches storage
  assign push = in_valid && in_ready && !(byp && out_ready);
`else
  assign out_valid = !empty;
  assign out_data = out_valid ? mem[rd_ptr[AW-1:0]] : '0;
  assign push = in_valid && in_ready;
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      init_done <= 1'b0;
    end else begin
      init_done <= 1'b1;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      count <= push && !pop ? count + CW'(1) : pop && !push ? count - CW'(1) : count;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end
endmodule

// File: tb/tb_arbiter_out_fifo.sv
// tb_arbiter_out_fifo: queue-based reference model and scoreboard for arbiter_out_fifo.
module tb_arbiter_out_fifo;
  localparam int DEPTH = 4;
  localparam int AFL = DEPTH - 1;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, almost_full;
  logic [15:0] out_data;
  logic [2:0] count;
  int checks = 0;
  int errors = 0;
  logic [15:0] q[$];
  bit init_m = 1'b0;

  arbiter_out_fifo #(.DWIDTH(16), .DEPTH(DEPTH), .AFULL_LVL(AFL)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .count(count),
    .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // reference model: the FIFO is a plain queue; each negedge compares, then applies the coming edge
  always @(negedge clk) begin
    bit ev, acc, pass;
    logic [15:0] ed;
    if (!reset) begin
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_count", count, 0);
      check("rst_almost_full", almost_full, 0);
      q.delete();
      init_m = 1'b0;
    end else begin
      ev = q.size() != 0;
      ed = ev ? q[0] : 16'h0;
`ifdef ARB_FIFO_BYPASS_EN
      if (!ev && in_valid && init_m) begin
        ev = 1'b1;
        ed = in_data;
      end
`endif
      check("in_ready", in_ready, init_m && q.size() < DEPTH);
      check("out_valid", out_valid, ev);
      check("out_data", out_data, ed);
      check("count", count, q.size());
      check("almost_full", almost_full, q.size() >= AFL);
      acc = in_valid && init_m && q.size() < DEPTH;
      pass = 1'b0;
      if (ev && out_ready) begin
        if (q.size() != 0) void'(q.pop_front());
        else pass = 1'b1;
      end
      if (acc && !pass) q.push_back(in_data);
      init_m = 1'b1;
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(logic [15:0] w);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data = w;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("send_accepted", ok, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    in_valid = 1'b1;
    in_data = 16'h0bad;
    out_ready = 1'b1;
    tick(3);
    reset = 1'b1;
    send(16'h0bad);
    tick(3);
    out_ready = 1'b0;
    send(16'h0011);
    send(16'h0022);
    send(16'h0033);
    send(16'h0044);
    in_valid = 1'b1;
    in_data = 16'h0055;
    tick(3);
    out_ready = 1'b1;
    send(16'h0055);
    tick(8);
    for (int i = 0; i < 20; i++) send(16'(i));
    tick(3);
    out_ready = 1'b0;
    send(16'h00a1);
    send(16'h00a2);
    out_ready = 1'b1;
    for (int i = 3; i < 7; i++) send(16'h00a0 + 16'(i));
    tick(4);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(16'h00b0 + 16'(i));
    in_valid = 1'b1;
    in_data = 16'h00b4;
    tick(2);
    out_ready = 1'b1;
    send(16'h00b4);
    tick(6);
    out_ready = 1'b0;
    send(16'h00c1);
    send(16'h00c2);
    send(16'h00c3);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_count", count, 0);
    check("async_in_ready", in_ready, 0);
    check("async_out_data", out_data, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    out_ready = 1'b1;
    send(16'h00aa);
    tick(4);
    in_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc || !in_valid) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data = 16'($urandom);
      end
      out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/arbiter_out_fifo.md
# arbiter_out_fifo

Valid/ready FIFO that sits directly downstream of the 2-input round-robin arbiter and decouples the arbitrated stream from the consuming stage. Its input port is the arbiter's output (`out_valid`/`out_data`/`out_ready`), so the arbiter sees a registered `in_ready` with no combinational path back from the consumer. It absorbs short consumer stalls without stalling the arbiter's grant rotation, and reports occupancy for flow-control monitoring.

## Interface
- `DWIDTH`, default 16: payload width; must equal the upstream arbiter `DWIDTH`.
- `DEPTH`, default 4: number of entries; power of two, at least 2.
- `AFULL_LVL`, default `DEPTH-1`: `almost_full` asserts when `count >= AFULL_LVL`; legal range 1..`DEPTH`.
- `clk`, input, 1: single clock; all logic is rising-edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: upstream word valid.
- `in_data`, input, `DWIDTH`: upstream word.
- `in_ready`, output, 1: FIFO can accept a word this cycle.
- `out_valid`, output, 1: head word available.
- `out_data`, output, `DWIDTH`: head word.
- `out_ready`, input, 1: consumer accepts the head word.
- `count`, output, `$clog2(DEPTH+1)`: stored entries, 0..`DEPTH`.
- `almost_full`, output, 1: occupancy threshold flag.

## Operation
- Storage is a circular buffer.
  - `wr_ptr` and `rd_ptr` are each `$clog2(DEPTH)+1` bits; the MSB is the wrap bit.
  - Empty when the pointers are equal.
  - Full when the index bits are equal and the wrap bits differ.
- Push: `in_valid && in_ready`. The word is written at `wr_ptr`, then `wr_ptr` increments. Index wrap from `DEPTH-1` to 0 toggles the wrap bit.
- Pop: `out_valid && out_ready`. `rd_ptr` increments with the same wrap rule.
- `count` is a register: +1 on push only, -1 on pop only, unchanged on both or neither.
- `in_ready = !full && init_done`.
  - `init_done` is a flop cleared by reset and set on the first clock edge after reset deasserts.
  - `in_ready` never depends on `out_ready` or `in_valid`.
- `out_valid = !empty`.
  - `out_data = mem[rd_ptr index]` while `out_valid=1`.
  - `out_data` is forced to 0 while `out_valid=0`.
- Full plus consumer pop in the same cycle: no push is accepted, because `in_ready` was 0. Space frees up on the next cycle.
- Empty plus push: without the bypass feature, the word appears on `out_valid` one cycle later.
- Upstream contract, not checked by the FIFO: once `in_valid` is high, it and `in_data` stay stable until accepted.
- Output guarantee: once `out_valid` is high, `out_valid` and `out_data` hold until popped.
- Reset is asynchronous and may assert mid-operation. It immediately clears:
  - pointers, `count` and `init_done`;
  - therefore `out_valid=0`, `out_data=0`, `in_ready=0`, `almost_full=0`.
  - All in-flight contents are discarded; memory contents are not reset.

## Timing
- Reset values: `in_ready=0`, `out_valid=0`, `out_data=0`, `count=0`, `almost_full=0`.
- `in_ready` rises 1 cycle after reset deasserts.
- Latency from push to `out_valid`: 1 cycle. With the bypass feature and the FIFO empty, latency is 0.
- Throughput: 1 word per cycle sustained when `out_ready=1`, at any occupancy.
- `count` and `almost_full` update on the clock edge after the push or pop.
- `in_ready` falls on the edge where `count` reaches `DEPTH`, and rises on the edge after a pop from full.

## Configuration
- Macro: `ARB_FIFO_BYPASS_EN`.
- When defined, the empty-FIFO fall-through path is enabled:
  - While empty: `out_valid = in_valid && init_done` and `out_data = in_data`.
  - If `out_ready=1` in that cycle, the word passes straight through. It is not written, and the pointers and `count` do not change.
  - If `out_ready=0`, the word is written normally.
  - `in_ready` is unchanged: still registered-only.
- When not defined: there is no combinational `in_*` to `out_*` path, and latency is always 1 cycle.

## Test plan
- Reset release:
  - Hold `reset=0` for 3 cycles with `in_valid=1`, then deassert.
  - Required: all outputs at reset values during reset, `in_ready=1` exactly one edge after release, no word stored before then.
- Fill and drain, `DEPTH=4`, `out_ready=0`:
  - Push 0x0011, 0x0022, 0x0033, 0x0044.
  - Required: `count` goes 1→4; `almost_full=1` at `count=3`; `in_ready=0` at 4; a fifth word 0x0055 is held off.
  - Then raise `out_ready`. Required: 0x0011..0x0044 come out in order, followed by 0x0055.
- Streaming wrap-around:
  - 20 consecutive words 0..19 with `in_valid=1` and `out_ready=1`.
  - Required: output 0..19 in order, one per cycle after the first; `count` never above 1; pointers wrap ≥4 times.
- Simultaneous push/pop at `count=2`:
  - Required: `count` stays 2 and data order is preserved.
  - At full with `out_ready=1`: required `count` 4→3, `in_ready` back to 1 on the next cycle.
- Mid-operation reset:
  - With `count=3`, assert `reset` between clock edges.
  - Required: `out_valid`, `count` and `in_ready` drop to 0 immediately (asynchronously). After release, the first new word 0x00AA is the first word out.
- `ARB_FIFO_BYPASS_EN` defined, FIFO empty, `out_ready=1`, push 0x1234:
  - Required: `out_valid=1` and `out_data=0x1234` in the same cycle, `count` stays 0.
  - Repeat with `out_ready=0`: required `count=1`, and the word is held on `out_data`.
